// File: rtl/ts_sync_aligner.sv
`default_nettype none
// ============================================================================
// Module   : ts_sync_aligner
// Brief    : MPEG-TS sync-byte hunter/locker; captures header bytes 0..3 of
//            each locked packet for the downstream continuity checker.
// Revision : 1.0 - initial release
// ============================================================================
module ts_sync_aligner #(
    parameter int PKT_LEN    = 188,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ts_data,
    input  logic        ts_valid,
    output logic [7:0]  r_data1,
    output logic [7:0]  r_data2,
    output logic [7:0]  r_data3,
    output logic [7:0]  r_data4,
    output logic        hdr_valid,
    output logic        pkt_start,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] sync_loss_cnt
);

    localparam logic [1:0] c_HUNT       = 2'd0;
    localparam logic [1:0] c_VERIFY     = 2'd1;
    localparam logic [1:0] c_LOCKED     = 2'd2;
    localparam logic [7:0] c_SYNC       = 8'h47;
    localparam logic [7:0] c_LAST_POS   = 8'(PKT_LEN - 1);
    localparam logic [7:0] c_LOCK_CNT   = 8'(LOCK_CNT);
    localparam logic [7:0] c_UNLOCK_CNT = 8'(UNLOCK_CNT);

    logic [1:0] r_state, w_state_nxt;
    logic [7:0] r_pos, w_pos_nxt, w_pos_inc;
    logic [7:0] r_good_cnt, w_good_nxt, w_good_inc;
    logic [7:0] r_miss_cnt, w_miss_nxt, w_miss_inc;
    logic       r_hdr_good, w_hdr_good_nxt;
    logic       w_is_sync, w_cap0, w_pkt_start, w_sync_err, w_hdr_valid, w_lost;

    assign w_is_sync  = (ts_data == c_SYNC);
    assign w_pos_inc  = (r_pos == c_LAST_POS) ? 8'd0 : r_pos + 8'd1;
    assign w_good_inc = r_good_cnt + 8'd1;
    assign w_miss_inc = r_miss_cnt + 8'd1;
    assign locked     = (r_state == c_LOCKED);

    always_comb begin
        w_state_nxt    = r_state;
        w_pos_nxt      = r_pos;
        w_good_nxt     = r_good_cnt;
        w_miss_nxt     = r_miss_cnt;
        w_hdr_good_nxt = r_hdr_good;
        w_cap0         = 1'b0;
        w_pkt_start    = 1'b0;
        w_sync_err     = 1'b0;
        w_hdr_valid    = 1'b0;
        w_lost         = 1'b0;
        if (ts_valid) begin
            case (r_state)
                c_HUNT: begin
                    if (w_is_sync) begin
                        w_pos_nxt  = 8'd1;
                        w_good_nxt = 8'd1;
                        if (c_LOCK_CNT <= 8'd1) begin
                            w_state_nxt    = c_LOCKED;
                            w_miss_nxt     = 8'd0;
                            w_hdr_good_nxt = 1'b1;
                            w_cap0         = 1'b1;
                        end else begin
                            w_state_nxt = c_VERIFY;
                        end
                    end
                end
                c_VERIFY: begin
                    w_pos_nxt = w_pos_inc;
                    if (r_pos == 8'd0) begin
                        if (w_is_sync) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc >= c_LOCK_CNT) begin
                                w_state_nxt    = c_LOCKED;
                                w_miss_nxt     = 8'd0;
                                w_hdr_good_nxt = 1'b1;
                                w_cap0         = 1'b1;
                            end
                        end else begin
                            // Failed candidate: the bad byte is consumed, hunting resumes on the next one.
                            w_state_nxt = c_HUNT;
                            w_pos_nxt   = 8'd0;
                            w_good_nxt  = 8'd0;
                        end
                    end
                end
                c_LOCKED: begin
                    w_pos_nxt = w_pos_inc;
                    if (r_pos == 8'd0) begin
                        w_pkt_start = 1'b1;
                        w_cap0      = 1'b1;
                        if (w_is_sync) begin
                            w_miss_nxt     = 8'd0;
                            w_hdr_good_nxt = 1'b1;
                        end else begin
                            w_hdr_good_nxt = 1'b0;
                            w_sync_err     = 1'b1;
                            w_miss_nxt     = w_miss_inc;
                            if (w_miss_inc >= c_UNLOCK_CNT) begin
                                w_state_nxt = c_HUNT;
                                w_pos_nxt   = 8'd0;
                                w_good_nxt  = 8'd0;
                                w_miss_nxt  = 8'd0;
                                w_lost      = 1'b1;
                            end
                        end
                    end
                    if (r_pos == 8'd3 && r_hdr_good) begin
                        w_hdr_valid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_HUNT;
                    w_pos_nxt   = 8'd0;
                    w_good_nxt  = 8'd0;
                    w_miss_nxt  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_HUNT;
            r_pos         <= 8'd0;
            r_good_cnt    <= 8'd0;
            r_miss_cnt    <= 8'd0;
            r_hdr_good    <= 1'b0;
            r_data1       <= 8'h00;
            r_data2       <= 8'h00;
            r_data3       <= 8'h00;
            r_data4       <= 8'h00;
            hdr_valid     <= 1'b0;
            pkt_start     <= 1'b0;
            sync_err      <= 1'b0;
            sync_loss_cnt <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_pos      <= w_pos_nxt;
            r_good_cnt <= w_good_nxt;
            r_miss_cnt <= w_miss_nxt;
            r_hdr_good <= w_hdr_good_nxt;
            hdr_valid  <= w_hdr_valid;
            pkt_start  <= w_pkt_start;
            sync_err   <= w_sync_err;
            if (w_lost && sync_loss_cnt != 16'hFFFF) begin
                sync_loss_cnt <= sync_loss_cnt + 16'd1;
            end
            if (w_cap0) begin
                r_data1 <= ts_data;
            end
            if (ts_valid && r_state == c_LOCKED) begin
                case (r_pos)
                    8'd1:    r_data2 <= ts_data;
                    8'd2:    r_data3 <= ts_data;
                    8'd3:    r_data4 <= ts_data;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ts_sync_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ts_sync_aligner
// Brief    : Randomized self-checking bench for ts_sync_aligner against a
//            per-byte behavioural model of the hunt/verify/lock rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ts_sync_aligner;

    localparam int c_PKT_LEN    = 188;
    localparam int c_LOCK_CNT   = 3;
    localparam int c_UNLOCK_CNT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ts_data = 8'h00;
    logic        ts_valid = 1'b0;
    logic [7:0]  r_data1, r_data2, r_data3, r_data4;
    logic        hdr_valid, pkt_start, locked, sync_err;
    logic [15:0] sync_loss_cnt;

    ts_sync_aligner #(
        .PKT_LEN    (c_PKT_LEN),
        .LOCK_CNT   (c_LOCK_CNT),
        .UNLOCK_CNT (c_UNLOCK_CNT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ts_data       (ts_data),
        .ts_valid      (ts_valid),
        .r_data1       (r_data1),
        .r_data2       (r_data2),
        .r_data3       (r_data3),
        .r_data4       (r_data4),
        .hdr_valid     (hdr_valid),
        .pkt_start     (pkt_start),
        .locked        (locked),
        .sync_err      (sync_err),
        .sync_loss_cnt (sync_loss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int hdr_seen = 0;
    int err_seen = 0;
    bit gap_en   = 1'b0;

    // Reference model: 0=hunting, 1=verifying a candidate, 2=locked
    int       m_mode, m_pos, m_good, m_miss, m_loss;
    bit       m_hdr_ok, m_hdr_v, m_pkt, m_err;
    bit [7:0] m_hdr [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit [7:0] d);
        int p;
        m_hdr_v = 0; m_pkt = 0; m_err = 0;
        if (r) begin
            m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_loss = 0; m_hdr_ok = 0;
            for (int i = 0; i < 4; i++) m_hdr[i] = 8'h00;
            return;
        end
        if (!v) return;
        p = m_pos;
        m_pos = (p + 1) % c_PKT_LEN;
        if (m_mode == 0) begin
            if (d == 8'h47) begin
                m_pos = 1; m_good = 1; m_mode = 1;
            end else begin
                m_pos = 0;
            end
        end else if (m_mode == 1) begin
            if (p == 0) begin
                if (d == 8'h47) begin
                    m_good++;
                    if (m_good >= c_LOCK_CNT) begin
                        m_mode = 2; m_miss = 0; m_hdr_ok = 1; m_hdr[0] = d;
                    end
                end else begin
                    m_mode = 0; m_pos = 0; m_good = 0;
                end
            end
        end else begin
            if (p == 0) begin
                m_pkt = 1;
                m_hdr[0] = d;
                if (d == 8'h47) begin
                    m_miss = 0; m_hdr_ok = 1;
                end else begin
                    m_hdr_ok = 0; m_err = 1; m_miss++;
                    if (m_miss >= c_UNLOCK_CNT) begin
                        m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0;
                        if (m_loss < 16'hFFFF) m_loss++;
                    end
                end
            end else if (p <= 3) begin
                m_hdr[p] = d;
                if (p == 3 && m_hdr_ok) m_hdr_v = 1;
            end
        end
    endtask

    task automatic step(input bit v, input bit [7:0] d, input bit r);
        ts_valid = v; ts_data = d; rst = r;
        @(posedge clk);
        #1;
        model_step(r, v, d);
        check("locked",    32'(locked),        32'(m_mode == 2));
        check("hdr_valid", 32'(hdr_valid),     32'(m_hdr_v));
        check("pkt_start", 32'(pkt_start),     32'(m_pkt));
        check("sync_err",  32'(sync_err),      32'(m_err));
        check("loss_cnt",  32'(sync_loss_cnt), 32'(m_loss));
        check("hdr_data",  {r_data1, r_data2, r_data3, r_data4},
                           {m_hdr[0], m_hdr[1], m_hdr[2], m_hdr[3]});
        if (hdr_valid) begin
            hdr_seen++;
            check("hdr_bytes", {r_data1, r_data2, r_data3, r_data4}, 32'h471FFF10);
        end
        if (sync_err) err_seen++;
    endtask

    task automatic send_byte(input bit [7:0] b);
        while (gap_en && ($urandom % 2 == 0)) step(1'b0, 8'($urandom), 1'b0);
        step(1'b1, b, 1'b0);
    endtask

    function automatic bit [7:0] payload(input bit allow47);
        bit [7:0] b;
        b = 8'($urandom);
        if (!allow47 && b == 8'h47) b = 8'h00;
        return b;
    endfunction

    // rst_at >= 0 asserts rst together with ts_valid on that packet position
    task automatic send_pkt(input bit [7:0] sync, input bit allow47, input int rst_at);
        bit [7:0] hdr [4];
        bit [7:0] b;
        hdr[0] = sync; hdr[1] = 8'h1F; hdr[2] = 8'hFF; hdr[3] = 8'h10;
        for (int i = 0; i < c_PKT_LEN; i++) begin
            b = (i < 4) ? hdr[i] : payload(allow47);
            if (i == rst_at) step(1'b1, b, 1'b1);
            else             send_byte(b);
        end
    endtask

    initial begin
        model_step(1'b1, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h47, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Clean aligned stream
        hdr_seen = 0;
        for (int k = 0; k < 6; k++) send_pkt(8'h47, 1'b0, -1);
        check("clean_hdr_count", 32'(hdr_seen), 32'd4);
        check("clean_locked",    32'(locked),   32'd1);

        // Garbage with a stray sync ahead of the true alignment
        step(1'b0, 8'h00, 1'b1);
        hdr_seen = 0;
        for (int i = 0; i < 20; i++) send_byte((i == 5) ? 8'h47 : payload(1'b0));
        for (int k = 0; k < 7; k++) send_pkt(8'h47, 1'b0, -1);
        check("stray_hdr_count", 32'(hdr_seen), 32'd4);
        check("stray_locked",    32'(locked),   32'd1);

        // Single corrupted sync while locked
        hdr_seen = 0; err_seen = 0;
        send_pkt(8'h46, 1'b0, -1);
        check("one_bad_locked", 32'(locked), 32'd1);
        for (int k = 0; k < 2; k++) send_pkt(8'h47, 1'b0, -1);
        check("one_bad_errs", 32'(err_seen), 32'd1);
        check("one_bad_hdrs", 32'(hdr_seen), 32'd2);

        // Three consecutive bad syncs, then relock
        hdr_seen = 0; err_seen = 0;
        for (int k = 0; k < 3; k++) send_pkt(8'h46, 1'b0, -1);
        check("loss_unlocked", 32'(locked),        32'd0);
        check("loss_count",    32'(sync_loss_cnt), 32'd1);
        for (int k = 0; k < 4; k++) send_pkt(8'h47, 1'b0, -1);
        check("loss_errs",   32'(err_seen), 32'd3);
        check("loss_hdrs",   32'(hdr_seen), 32'd2);
        check("loss_relock", 32'(locked),   32'd1);

        // Clean stream with random valid gaps
        step(1'b0, 8'h00, 1'b1);
        gap_en = 1'b1;
        hdr_seen = 0;
        for (int k = 0; k < 6; k++) send_pkt(8'h47, 1'b0, -1);
        check("gap_hdr_count", 32'(hdr_seen), 32'd4);
        check("gap_locked",    32'(locked),   32'd1);

        // Reset mid-packet while locked
        hdr_seen = 0;
        send_pkt(8'h47, 1'b0, 100);
        check("rst_mid_unlocked", 32'(locked), 32'd0);
        for (int k = 0; k < 2; k++) send_pkt(8'h47, 1'b0, -1);
        check("rst_mid_not_yet", 32'(locked), 32'd0);
        send_pkt(8'h47, 1'b0, -1);
        check("rst_mid_relock", 32'(locked),   32'd1);
        check("rst_mid_hdrs",   32'(hdr_seen), 32'd2);

        // Random mix of good/bad syncs, payload may hold 0x47
        for (int k = 0; k < 25; k++) begin
            send_pkt(($urandom % 4 == 0) ? 8'(8'h47 ^ (8'd1 << ($urandom % 8))) : 8'h47,
                     1'b1, -1);
        end
        gap_en = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ts_sync_aligner.md
TS_SYNC_ALIGNER -- requirements
Module: ts_sync_aligner

Interface
REQ-001 Parameter PKT_LEN, 188, packet length in bytes (valid range 8..255).
REQ-002 Parameter LOCK_CNT, 3, consecutive good sync bytes at PKT_LEN spacing required to lock, hunt-phase 0x47 included.
REQ-003 Parameter UNLOCK_CNT, 3, consecutive bad sync bytes while locked that force loss of lock.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ts_data  in  8  incoming TS byte stream.
REQ-007 ts_valid  in  1  ts_data accepted on a rising edge where ts_valid=1; no backpressure.
REQ-008 r_data1..r_data4  out  8 each  captured header bytes 0..3 of the current packet; feed the continuity checker.
REQ-009 hdr_valid  out  1  one-cycle pulse: r_data1..r_data4 hold a complete, good-sync header.
REQ-010 pkt_start  out  1  one-cycle pulse when the byte at packet position 0 is accepted while locked.
REQ-011 locked  out  1  high while in LOCKED.
REQ-012 sync_err  out  1  one-cycle pulse when a position-0 byte is not 0x47 while locked.
REQ-013 sync_loss_cnt  out  16  count of LOCKED->HUNT transitions, saturating.

Function
REQ-014 The block SHALL implement states HUNT, VERIFY, LOCKED; ts_valid=0 cycles SHALL change no state, counter or position.
REQ-015 Position counter pos SHALL count accepted bytes 0..PKT_LEN-1 and wrap PKT_LEN-1 -> 0.
REQ-016 HUNT: accepted byte 0x47 -> VERIFY, pos=1, good_cnt=1; any other byte -> stay in HUNT.
REQ-017 VERIFY: accepted byte at pos=0 equal to 0x47 SHALL increment good_cnt; reaching LOCK_CNT -> LOCKED, else stay in VERIFY.
REQ-018 VERIFY: accepted byte at pos=0 not equal to 0x47 -> HUNT; that byte SHALL NOT be reused as a new sync candidate.
REQ-019 locked SHALL rise the cycle after the locking sync byte is accepted; that packet's header SHALL be emitted.
REQ-020 LOCKED: good sync at pos=0 SHALL clear miss_cnt; bad sync SHALL increment miss_cnt and pulse sync_err the next cycle.
REQ-021 LOCKED: when miss_cnt reaches UNLOCK_CNT -> HUNT, locked falls the next cycle, sync_loss_cnt increments (saturates at 0xFFFF).
REQ-022 r_data1..r_data4 SHALL capture accepted bytes at pos 0..3 in LOCKED (including the locking packet) and hold until overwritten.
REQ-023 hdr_valid SHALL pulse the cycle after the pos=3 byte is accepted, only if that packet's pos=0 byte was 0x47 and state is still LOCKED.
REQ-024 No hdr_valid SHALL be produced for a packet with bad sync, nor in HUNT/VERIFY.
REQ-025 pkt_start SHALL pulse the cycle after any pos=0 byte accepted in LOCKED, good or bad sync.

Reset
REQ-026 rst SHALL force state HUNT, pos=0, good_cnt=0, miss_cnt=0 on the next edge, including mid-packet.
REQ-027 Reset values: r_data1..r_data4=0x00, hdr_valid=0, pkt_start=0, locked=0, sync_err=0, sync_loss_cnt=0x0000.
REQ-028 rst SHALL take priority over ts_valid in the same cycle.

Verification
REQ-029 Clean stream, 0x47 every 188 bytes, header 0x47 0x1F 0xFF 0x10 -> locked high after 3rd sync; first hdr_valid with r_data1..4=47,1F,FF,10.
REQ-030 20 garbage bytes containing a stray 0x47 before the aligned stream -> VERIFY abandoned, HUNT re-entered, lock on true alignment, no hdr_valid before lock.
REQ-031 Locked, one corrupted sync byte (0x46) -> one sync_err, no hdr_valid for that packet, pkt_start still pulses, locked stays 1.
REQ-032 Locked, 3 consecutive bad syncs -> locked falls after the 3rd, sync_loss_cnt=1; relock after 3 good syncs.
REQ-033 ts_valid toggled randomly (~50%) on clean stream -> identical header sequence to REQ-029 run, alignment unaffected.
REQ-034 rst pulsed at pos=100 while locked -> all outputs at reset values next cycle, relock requires 3 fresh syncs.
